phys_reg_free_list: RTL and testbench

Circular free list of physical register IDs feeding the rename stage. Supplies the physical register written into the register map table as the new mapping for each renamed destination, and accepts physical registers released at commit. It is the producer side of the map-table update path: its `alloc_reg` output becomes the map table's new map value.

---
 rtl/phys_reg_free_list_if.sv | 24 ++
 rtl/phys_reg_free_list.sv | 83 ++++++++
 tb/tb_phys_reg_free_list.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_if.sv
// rtl/phys_reg_free_list_if.sv - allocate/free handshake bundle for the physical register free list
interface phys_reg_free_list_if #(
   parameter int W = 7
);
   logic         alloc_req;
   logic         alloc_valid;
   logic [W-1:0] alloc_reg;
   logic         free_valid;
   logic [W-1:0] free_reg;
   logic [W:0]   free_count;
   logic         overflow_err;

   // rename/commit side
   modport master (
      output alloc_req, free_valid, free_reg,
      input  alloc_valid, alloc_reg, free_count, overflow_err
   );

   // free list side
   modport slave (
      input  alloc_req, free_valid, free_reg,
      output alloc_valid, alloc_reg, free_count, overflow_err
   );
endinterface

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular free list of physical register IDs for rename
module phys_reg_free_list #(
   parameter int REG_FILE_ADDR_WIDTH = 7,
   parameter int NUM_ARCH_REGS       = 32
) (
   input logic                  clock,
   input logic                  reset_n,
   phys_reg_free_list_if.slave  bus
);
   localparam int W     = REG_FILE_ADDR_WIDTH;
   localparam int DEPTH = (1 << W) - NUM_ARCH_REGS;

   localparam logic [W:0]   DEPTH_C  = (W+1)'(DEPTH);
   localparam logic [W-1:0] LAST_PTR = W'(DEPTH - 1);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   logic [W:0]   r_count;
   logic         r_overflow_err;

   logic         w_not_empty;
   logic         w_alloc_fire;
   logic         w_free_live;
   logic         w_free_ok;
   logic         w_free_drop;
   logic [W-1:0] w_head_next;
   logic [W-1:0] w_tail_next;

   // A free into a full list is still accepted when the same edge allocates,
   // since the head slot is vacated; ID 0 (x0 mapping) is never returned.
   always_comb begin
      w_not_empty  = (r_count != '0);
      w_alloc_fire = bus.alloc_req && w_not_empty;
      w_free_live  = bus.free_valid && (bus.free_reg != '0);
      w_free_ok    = w_free_live && ((r_count < DEPTH_C) || w_alloc_fire);
      w_free_drop  = w_free_live && !w_free_ok;
      // depth is not a power of two, so pointers wrap explicitly
      w_head_next  = (r_head == LAST_PTR) ? '0 : r_head + W'(1);
      w_tail_next  = (r_tail == LAST_PTR) ? '0 : r_tail + W'(1);
   end

   // Entry storage: reset preloads the IDs not claimed by architectural state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= W'(NUM_ARCH_REGS + i);
         end
      end else if (w_free_ok) begin
         r_mem[r_tail] <= bus.free_reg;
      end
   end

   // Head/tail pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= DEPTH_C;
         r_overflow_err <= 1'b0;
      end else begin
         if (w_alloc_fire) begin
            r_head <= w_head_next;
         end
         if (w_free_ok) begin
            r_tail <= w_tail_next;
         end
         if (w_free_ok && !w_alloc_fire) begin
            r_count <= r_count + (W+1)'(1);
         end else if (w_alloc_fire && !w_free_ok) begin
            r_count <= r_count - (W+1)'(1);
         end
         if (w_free_drop) begin
            r_overflow_err <= 1'b1;
         end
      end
   end

   assign bus.alloc_valid  = w_not_empty;
   assign bus.alloc_reg    = r_mem[r_head];
   assign bus.free_count   = r_count;
   assign bus.overflow_err = r_overflow_err;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - randomized self-checking bench for phys_reg_free_list
module tb_phys_reg_free_list;
   localparam int W     = 7;
   localparam int NARCH = 32;
   localparam int DEPTH = (1 << W) - NARCH;

   logic clock;
   logic reset_n;

   phys_reg_free_list_if #(.W(W)) bus ();

   phys_reg_free_list #(
      .REG_FILE_ADDR_WIDTH (W),
      .NUM_ARCH_REGS       (NARCH)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec;
   int n_err;

   // reference model: FIFO of IDs in allocation order plus sticky error
   int q[$];
   bit m_ovf;

   function automatic void model_reset();
      q.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back(NARCH + i);
      m_ovf = 1'b0;
   endfunction

   function automatic void model_step(input bit a, input bit fv, input int fr);
      bit fire;
      bit accept;
      fire   = a && (q.size() > 0);
      accept = fv && (fr != 0) && ((q.size() < DEPTH) || fire);
      if (fire) void'(q.pop_front());
      if (accept) q.push_back(fr);
      if (fv && (fr != 0) && !accept) m_ovf = 1'b1;
   endfunction

   // called at a falling edge; returns at the next falling edge
   task automatic cycle(input bit a, input bit fv, input int fr);
      bus.alloc_req  = a;
      bus.free_valid = fv;
      bus.free_reg   = W'(fr);
      @(posedge clock);
      model_step(a, fv, fr);
      @(negedge clock);
      bus.alloc_req  = 1'b0;
      bus.free_valid = 1'b0;
      bus.free_reg   = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      bus.alloc_req  = 1'b0;
      bus.free_valid = 1'b0;
      bus.free_reg   = '0;
      reset_n = 1'b0;
      model_reset();
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if (bus.alloc_valid !== 1'b1) begin
         n_err++; $display("FAIL reset_valid: got %b want 1", bus.alloc_valid);
      end
      n_vec++;
      if (bus.alloc_reg !== W'(NARCH)) begin
         n_err++; $display("FAIL reset_reg: got %0d want %0d", bus.alloc_reg, NARCH);
      end
      n_vec++;
      if (bus.free_count !== (W+1)'(DEPTH)) begin
         n_err++; $display("FAIL reset_count: got %0d want %0d", bus.free_count, DEPTH);
      end
      n_vec++;
      if (bus.overflow_err !== 1'b0) begin
         n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_err);
      end
   endtask

   task automatic test_drain();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         n_vec++;
         if (bus.alloc_valid !== 1'b1 || bus.alloc_reg !== W'(NARCH + i)) begin
            n_err++;
            $display("FAIL drain_seq[%0d]: got v=%b reg=%0d want v=1 reg=%0d",
                     i, bus.alloc_valid, bus.alloc_reg, NARCH + i);
         end
         cycle(1'b1, 1'b0, 0);
      end
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (bus.alloc_valid !== 1'b0 || bus.free_count !== '0 || bus.overflow_err !== 1'b0) begin
            n_err++;
            $display("FAIL drain_empty[%0d]: got v=%b cnt=%0d ovf=%b want 0/0/0",
                     k, bus.alloc_valid, bus.free_count, bus.overflow_err);
         end
         cycle(1'b1, 1'b0, 0);
      end
   endtask

   // relies on the list being empty from test_drain
   task automatic test_empty_refill();
      n_vec++;
      if (bus.alloc_valid !== 1'b0) begin
         n_err++; $display("FAIL refill_pre: got valid=%b want 0", bus.alloc_valid);
      end
      cycle(1'b0, 1'b1, 5);
      n_vec++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_reg !== W'(5) || bus.free_count !== (W+1)'(1)) begin
         n_err++;
         $display("FAIL refill_post: got v=%b reg=%0d cnt=%0d want 1/5/1",
                  bus.alloc_valid, bus.alloc_reg, bus.free_count);
      end
   endtask

   task automatic test_simul_full();
      do_reset();
      cycle(1'b1, 1'b1, 7);
      n_vec++;
      if (bus.alloc_reg !== W'(33) || bus.free_count !== (W+1)'(DEPTH) || bus.overflow_err !== 1'b0) begin
         n_err++;
         $display("FAIL simul_full: got reg=%0d cnt=%0d ovf=%b want 33/%0d/0",
                  bus.alloc_reg, bus.free_count, bus.overflow_err, DEPTH);
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (bus.alloc_reg !== W'(33 + i)) begin
            n_err++; $display("FAIL simul_seq[%0d]: got %0d want %0d", i, bus.alloc_reg, 33 + i);
         end
         n_vec++;
         cycle(1'b1, 1'b0, 0);
      end
      n_vec++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_reg !== W'(7) || bus.free_count !== (W+1)'(1)) begin
         n_err++;
         $display("FAIL simul_wrap: got v=%b reg=%0d cnt=%0d want 1/7/1",
                  bus.alloc_valid, bus.alloc_reg, bus.free_count);
      end
      // count=1 with simultaneous alloc+free: freed ID becomes head
      cycle(1'b1, 1'b1, 99);
      n_vec++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_reg !== W'(99) || bus.free_count !== (W+1)'(1)) begin
         n_err++;
         $display("FAIL simul_one: got v=%b reg=%0d cnt=%0d want 1/99/1",
                  bus.alloc_valid, bus.alloc_reg, bus.free_count);
      end
   endtask

   task automatic test_overflow_x0();
      do_reset();
      cycle(1'b0, 1'b1, 10);
      n_vec++;
      if (bus.overflow_err !== 1'b1 || bus.free_count !== (W+1)'(DEPTH) || bus.alloc_reg !== W'(NARCH)) begin
         n_err++;
         $display("FAIL overflow: got ovf=%b cnt=%0d reg=%0d want 1/%0d/%0d",
                  bus.overflow_err, bus.free_count, bus.alloc_reg, DEPTH, NARCH);
      end
      cycle(1'b0, 1'b0, 0);
      n_vec++;
      if (bus.overflow_err !== 1'b1) begin
         n_err++; $display("FAIL overflow_sticky: got %b want 1", bus.overflow_err);
      end
      do_reset();
      for (int i = 0; i < DEPTH - 50; i++) cycle(1'b1, 1'b0, 0);
      cycle(1'b0, 1'b1, 0);
      n_vec++;
      if (bus.free_count !== (W+1)'(50) || bus.overflow_err !== 1'b0 || bus.alloc_reg !== W'(NARCH + DEPTH - 50)) begin
         n_err++;
         $display("FAIL x0_free: got cnt=%0d ovf=%b reg=%0d want 50/0/%0d",
                  bus.free_count, bus.overflow_err, bus.alloc_reg, NARCH + DEPTH - 50);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 0);
      n_vec++;
      if (bus.alloc_reg !== W'(NARCH + 40) || bus.free_count !== (W+1)'(DEPTH - 40)) begin
         n_err++;
         $display("FAIL async_pre: got reg=%0d cnt=%0d want %0d/%0d",
                  bus.alloc_reg, bus.free_count, NARCH + 40, DEPTH - 40);
      end
      // at a falling edge: assert reset between edges, observe before next rise
      #2;
      reset_n = 1'b0;
      #1;
      n_vec++;
      if (bus.alloc_valid !== 1'b1 || bus.alloc_reg !== W'(NARCH) ||
          bus.free_count !== (W+1)'(DEPTH) || bus.overflow_err !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got v=%b reg=%0d cnt=%0d ovf=%b want 1/%0d/%0d/0",
                  bus.alloc_valid, bus.alloc_reg, bus.free_count, bus.overflow_err, NARCH, DEPTH);
      end
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      cycle(1'b1, 1'b0, 0);
      n_vec++;
      if (bus.alloc_reg !== W'(NARCH + 1)) begin
         n_err++; $display("FAIL async_after: got %0d want %0d", bus.alloc_reg, NARCH + 1);
      end
   endtask

   task automatic test_random();
      int p_alloc [4] = '{90, 10, 50, 97};
      int p_free  [4] = '{30, 85, 50, 5};
      do_reset();
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 500; c++) begin
            bit a;
            bit fv;
            int fr;
            n_vec++;
            if (bus.alloc_valid !== (q.size() > 0) ||
                bus.free_count !== (W+1)'(q.size()) ||
                bus.overflow_err !== m_ovf ||
                (q.size() > 0 && bus.alloc_reg !== W'(q[0]))) begin
               n_err++;
               $display("FAIL random[%0d/%0d]: got v=%b reg=%0d cnt=%0d ovf=%b want v=%0d reg=%0d cnt=%0d ovf=%b",
                        ph, c, bus.alloc_valid, bus.alloc_reg, bus.free_count, bus.overflow_err,
                        q.size() > 0, (q.size() > 0) ? q[0] : -1, q.size(), m_ovf);
            end
            a  = ($urandom_range(0, 99) < p_alloc[ph]);
            fv = ($urandom_range(0, 99) < p_free[ph]);
            fr = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
            cycle(a, fv, fr);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset_n        = 1'b1;
      bus.alloc_req  = 1'b0;
      bus.free_valid = 1'b0;
      bus.free_reg   = '0;
      model_reset();
      test_reset();
      test_drain();
      test_empty_refill();
      test_simul_full();
      test_overflow_x0();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
